// File: rtl/dsi_lane_packet_scheduler_pkg.sv
// Shared types and constants for the DSI lane packet scheduler.
//   sched_state_t : scheduler FSM states
//   SCHED_DATA_W  : default payload width
//   FIFO_W        : lane FIFO word width {lp, data}
//   LP_BIT        : bit index of the LP flag in a FIFO word (bridge reads it as mode_lp)
package dsi_sched_pkg;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_XFER, S_DRAIN, S_GAP} sched_state_t;

  localparam int SCHED_DATA_W = 32;
  localparam int FIFO_W       = SCHED_DATA_W + 1;
  localparam int LP_BIT       = SCHED_DATA_W;

endpackage

// File: rtl/dsi_lane_packet_scheduler_if.sv
// Requester and lane-FIFO handshake bundle of the DSI lane packet scheduler.
//   master : scheduler side (samples requests and FIFO status, drives ready and FIFO writes)
//   slave  : requesters plus lane FIFO side
interface dsi_lane_packet_scheduler_if
  import dsi_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = SCHED_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_lp;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W:0]           fifo_wdata;
  logic                      fifo_write;
  logic                      fifo_full;
  logic                      fifo_empty;

  modport master (
    input  req_valid, req_data, req_lp, req_last, fifo_full, fifo_empty,
    output req_ready, fifo_wdata, fifo_write
  );

  modport slave (
    output req_valid, req_data, req_lp, req_last, fifo_full, fifo_empty,
    input  req_ready, fifo_wdata, fifo_write
  );
endinterface

// File: rtl/dsi_lane_packet_scheduler_arbiter.sv
// dsi_rr_arbiter: combinational round-robin pick.
//   req        in  NUM_REQ  request vector
//   last_grant in  IDX_W    previously granted index; search starts one above it
//   grant      out IDX_W    chosen index (0 when nothing requests)
//   any        out 1        at least one request present
module dsi_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any
);

  // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (req[idx]) grant = idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/dsi_lane_packet_scheduler.sv
// dsi_lane_packet_scheduler: shares one DSI lane between NUM_REQ packet sources.
// Grants whole packets round-robin, writes {lp, data} words into the lane FIFO and
// separates packets into distinct lane bursts (FIFO drain plus gap_cycles idle).
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (master)      requester valid/data/lp/last/ready, FIFO wdata/write/full/empty
//   gap_cycles        idle cycles after the FIFO empties, sampled on DRAIN exit
//   grant_id          current/last granted requester
//   busy              scheduler not in IDLE
//   video_starve_cnt  only with DSI_SCHED_VIDEO_PRIO_EN: DRAIN+GAP cycles while req 0 waits
// Optional feature macro: DSI_SCHED_VIDEO_PRIO_EN (requester 0 gets strict priority).
module dsi_lane_packet_scheduler
  import dsi_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = SCHED_DATA_W,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dsi_lane_packet_scheduler_if.master bus,
  input  logic [15:0]                 gap_cycles,
  output logic [IDX_W-1:0]            grant_id,
  output logic                        busy
`ifdef DSI_SCHED_VIDEO_PRIO_EN
  ,
  output logic [15:0]                 video_starve_cnt
`endif
);

  sched_state_t       state;
  logic [IDX_W-1:0]   last_grant;
  logic               lp_cur;
  logic               lp_prev;
  logic [15:0]        gap_cnt;

  logic [NUM_REQ-1:0] arb_req;
  logic [IDX_W-1:0]   pick;
  logic               pick_any;
  logic [IDX_W-1:0]   sel;
  logic               sel_any;
  logic               sel_moves_ptr;

  logic               xfer;
  logic               accept;
  logic [DATA_W-1:0]  g_data;

`ifdef DSI_SCHED_VIDEO_PRIO_EN
  // Requester 0 is handled outside the rotation so the others share it fairly.
  assign arb_req = {bus.req_valid[NUM_REQ-1:1], 1'b0};
`else
  assign arb_req = bus.req_valid;
`endif

  dsi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (arb_req),
    .last_grant (last_grant),
    .grant      (pick),
    .any        (pick_any)
  );

  always_comb begin
    sel           = pick;
    sel_any       = pick_any;
    sel_moves_ptr = 1'b1;
`ifdef DSI_SCHED_VIDEO_PRIO_EN
    if (bus.req_valid[0]) begin
      sel           = '0;
      sel_any       = 1'b1;
      sel_moves_ptr = 1'b0;
    end
`endif
  end

  assign xfer           = (state == S_XFER);
  assign g_data         = bus.req_data[grant_id*DATA_W +: DATA_W];
  assign accept         = xfer && bus.req_valid[grant_id] && !bus.fifo_full;
  assign bus.req_ready  = (xfer && !bus.fifo_full) ? (NUM_REQ'(1) << grant_id) : '0;
  assign bus.fifo_write = accept;
  assign bus.fifo_wdata = xfer ? {lp_cur, g_data} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant_id   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      lp_cur     <= 1'b0;
      lp_prev    <= 1'b1;
      gap_cnt    <= '0;
      busy       <= 1'b0;
`ifdef DSI_SCHED_VIDEO_PRIO_EN
      video_starve_cnt <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_any) begin
            grant_id <= sel;
            if (sel_moves_ptr) last_grant <= sel;
            lp_cur   <= bus.req_lp[sel];
            state    <= S_GRANT;
            busy     <= 1'b1;
          end
        end
        S_GRANT: begin
          // A mode change must not share a burst with words still queued in the FIFO.
          if (!((lp_cur != lp_prev) && !bus.fifo_empty)) state <= S_XFER;
        end
        S_XFER: begin
          if (accept && bus.req_last[grant_id]) begin
            lp_prev <= lp_cur;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.fifo_empty) begin
            if (gap_cycles == 16'd0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cycles - 16'd1;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == 16'd0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
`ifdef DSI_SCHED_VIDEO_PRIO_EN
      if ((state == S_DRAIN || state == S_GAP) && bus.req_valid[0] &&
          video_starve_cnt != 16'hFFFF)
        video_starve_cnt <= video_starve_cnt + 16'd1;
`endif
    end
  end

  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    bus.fifo_full |-> !bus.fifo_write);

endmodule

// File: tb/tb_dsi_lane_packet_scheduler.sv
// Directed self-checking bench for dsi_lane_packet_scheduler.
// Requester sources and a one-word-per-cycle lane FIFO drain are modelled in the bench.
module tb_dsi_lane_packet_scheduler;
  import dsi_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] gap_cycles = 16'd0;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef DSI_SCHED_VIDEO_PRIO_EN
  logic [15:0] video_starve_cnt;
`endif

  dsi_lane_packet_scheduler_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

  dsi_lane_packet_scheduler #(.NUM_REQ(4), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .gap_cycles (gap_cycles),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef DSI_SCHED_VIDEO_PRIO_EN
    ,
    .video_starve_cnt (video_starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Requester sources: word = {req index, packet number, word index}
  int   pkt_left[4] = '{0, 0, 0, 0};
  int   wpp[4]      = '{1, 1, 1, 1};
  int   widx[4]     = '{0, 0, 0, 0};
  int   pktno[4]    = '{0, 0, 0, 0};
  logic src_lp[4]   = '{1'b0, 1'b0, 1'b0, 1'b0};

  int   fifo_cnt = 0;
  logic force_full = 1'b0;
  logic drain_en = 1'b1;

  always_comb begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_lp    = '0;
    bus.req_data  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]          = pkt_left[i] > 0;
      bus.req_last[i]           = widx[i] == wpp[i] - 1;
      bus.req_lp[i]             = src_lp[i];
      bus.req_data[i*32 +: 32]  = {8'(i), 8'(pktno[i]), 16'(widx[i])};
    end
  end

  assign bus.fifo_full  = force_full || (fifo_cnt >= 16);
  assign bus.fifo_empty = (fifo_cnt == 0);

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] wlog[$];
  int          wcyc[$];
  int          glog[$];
  int          cyc = 0;
  logic        busy_q = 1'b0;
  logic        post_last = 1'b0;
  int          post_cnt = 0;
  int          last_post = -1;
  int          fullbad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, update source/FIFO models just after posedge.
  task automatic step();
    logic       wr;
    logic [3:0] acc;
    logic       drained;
    @(negedge clk);
    wr  = bus.fifo_write;
    acc = bus.req_valid & bus.req_ready;
    if (bus.fifo_full && (wr || bus.req_ready != 4'b0)) fullbad++;
    if (wr) begin
      wlog.push_back(bus.fifo_wdata);
      wcyc.push_back(cyc);
    end
    if (busy && !busy_q) glog.push_back(int'(grant_id));
    // Counts DRAIN-exit plus GAP cycles: busy with the FIFO empty after the last word.
    if (post_last && busy && bus.fifo_empty) post_cnt++;
    if (wr && bus.req_last[grant_id]) post_last = 1'b1;
    if (!busy && busy_q) begin
      last_post = post_cnt;
      post_cnt  = 0;
      post_last = 1'b0;
    end
    busy_q = busy;
    cyc++;
    @(posedge clk);
    #1;
    drained  = drain_en && fifo_cnt > 0;
    fifo_cnt = fifo_cnt + int'(wr) - int'(drained);
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        if (widx[i] == wpp[i] - 1) begin
          widx[i] = 0;
          pktno[i]++;
          pkt_left[i]--;
        end else begin
          widx[i]++;
        end
      end
    end
  endtask

  task automatic wait_writes(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (wlog.size() < target && k < budget) begin
      step();
      k++;
    end
    check(tag, 64'(wlog.size()), 64'(target));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy_q != 1'b0 && k < budget) begin
      step();
      k++;
    end
    check(tag, 64'(busy_q), 64'd0);
  endtask

  task automatic clear_logs();
    wlog.delete();
    wcyc.delete();
    glog.delete();
  endtask

  initial begin
    int ord[5];
    int base[4];

    // Reset state, with a request already pending
    pkt_left[1] = 1; wpp[1] = 3; src_lp[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  64'(bus.req_ready), 64'd0);
    check("rst_write",  64'(bus.fifo_write), 64'd0);
    check("rst_wdata",  64'(bus.fifo_wdata), 64'd0);
    check("rst_grant",  64'(grant_id), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);

    // 1: req1 only, 3-word HS packet, gap 0
    rst_n = 1'b1;
    wait_writes(3, 20, "t1_writes");
    check("t1_grant", 64'(glog[0]), 64'd1);
    check("t1_consecutive", 64'(wcyc[2] - wcyc[0]), 64'd2);
    for (int j = 0; j < 3; j++)
      check("t1_word", 64'(wlog[j]), 64'({1'b0, 8'd1, 8'd0, 16'(j)}));
    wait_idle(20, "t1_idle");
    check("t1_drain_to_idle", 64'(last_post), 64'd1);

    // 2: all four valid, 2-word packets, after reset the pointer starts at 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      base[i] = pktno[i];
      wpp[i] = 2;
      src_lp[i] = 1'b0;
      pkt_left[i] = (i == 0) ? 2 : 1;
    end
    ord = '{0, 1, 2, 3, 0};
    wait_writes(10, 100, "t2_writes");
    wait_idle(20, "t2_idle");
    check("t2_grant_count", 64'(glog.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      check("t2_grant_order", 64'(glog[k]), 64'(ord[k]));
      for (int j = 0; j < 2; j++)
        check("t2_word", 64'(wlog[2*k+j]),
              64'({1'b0, 8'(ord[k]), 8'(base[ord[k]] + ((k == 4) ? 1 : 0)), 16'(j)}));
    end

    // 3: fifo_full held 5 cycles mid-packet
    clear_logs();
    base[2] = pktno[2];
    wpp[2] = 6; pkt_left[2] = 1;
    wait_writes(2, 20, "t3_first_words");
    force_full = 1'b1;
    repeat (5) step();
    check("t3_no_write_while_full", 64'(wlog.size()), 64'd2);
    check("t3_ready_write_when_full", 64'(fullbad), 64'd0);
    force_full = 1'b0;
    wait_writes(6, 30, "t3_writes");
    for (int j = 0; j < 6; j++)
      check("t3_word", 64'(wlog[j]), 64'({1'b0, 8'd2, 8'(base[2]), 16'(j)}));
    wait_idle(20, "t3_idle");

    // 4: HS packet from req0 left in the FIFO, LP packet from req2 must wait for empty
    clear_logs();
    drain_en = 1'b0;
    base[0] = pktno[0];
    base[2] = pktno[2];
    wpp[0] = 4; src_lp[0] = 1'b0; pkt_left[0] = 1;
    wpp[2] = 2; src_lp[2] = 1'b1; pkt_left[2] = 1;
    wait_writes(4, 20, "t4_hs_words");
    repeat (8) step();
    check("t4_held_no_write", 64'(wlog.size()), 64'd4);
    check("t4_held_busy", 64'(busy_q), 64'd1);
    drain_en = 1'b1;
    wait_writes(6, 40, "t4_lp_words");
    wait_idle(20, "t4_idle");
    check("t4_hs_lp_bit", 64'(wlog[3][LP_BIT]), 64'd0);
    check("t4_lp_first", 64'(wlog[4]), 64'({1'b1, 8'd2, 8'(base[2]), 16'd0}));
    check("t4_grant_a", 64'(glog[0]), 64'd0);
    check("t4_grant_b", 64'(glog[1]), 64'd2);

    // 5: gap timing with single-word packets; busy-with-empty cycles = DRAIN exit + gap
    clear_logs();
    src_lp[1] = 1'b0; wpp[1] = 1;
    gap_cycles = 16'd10;
    pkt_left[1] = 1;
    wait_writes(1, 20, "t5_gap10_write");
    wait_idle(40, "t5_gap10_idle");
    check("t5_gap10", 64'(last_post), 64'd11);
    clear_logs();
    gap_cycles = 16'd1;
    pkt_left[1] = 1;
    wait_writes(1, 20, "t5_gap1_write");
    wait_idle(40, "t5_gap1_idle");
    check("t5_gap1", 64'(last_post), 64'd2);
    gap_cycles = 16'd0;

    // 6: reset pulsed mid-XFER, partial packet stays in the FIFO
    clear_logs();
    drain_en = 1'b0;
    wpp[3] = 8; src_lp[3] = 1'b0; pkt_left[3] = 1;
    wait_writes(3, 20, "t6_partial");
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", 64'(bus.req_ready), 64'd0);
    check("t6_rst_write", 64'(bus.fifo_write), 64'd0);
    check("t6_rst_wdata", 64'(bus.fifo_wdata), 64'd0);
    check("t6_rst_grant", 64'(grant_id), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    step();
    pkt_left[3] = 0; widx[3] = 0;
    rst_n = 1'b1;
    clear_logs();
    wpp[1] = 2; pkt_left[1] = 1;
    wpp[3] = 2; pkt_left[3] = 1;
    repeat (6) step();
    check("t6_hold_no_write", 64'(wlog.size()), 64'd0);
    check("t6_grant_lowest", 64'(grant_id), 64'd1);
    check("t6_hold_busy", 64'(busy), 64'd1);
    drain_en = 1'b1;
    wait_writes(4, 60, "t6_writes");
    wait_idle(20, "t6_idle");
    check("t6_first_src", 64'(wlog[0][31:24]), 64'd1);
    check("t6_first_hs", 64'(wlog[0][LP_BIT]), 64'd0);
    check("t6_second_src", 64'(wlog[2][31:24]), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
